// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor: FSM state encoding
//   and the default operand width.
package serial_sub_pkg;

  localparam int SS_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_onebit_fs.sv
// onebit_fs
//   Combinational one-bit full subtractor: computes x - y - bin.
//   Ports:
//     x, y  : operand bits
//     bin   : borrow in
//     d     : difference bit
//     bout  : borrow out
module onebit_fs (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_sub.sv
// serial_sub
//   Bit-serial subtractor. A start in IDLE captures a and b, then one bit
//   per clock is processed LSB first through a single full subtractor.
//   After WIDTH shift cycles the result is published and done pulses for
//   one cycle.
//   Ports:
//     clk, rst    : clock, asynchronous active-high reset
//     start       : begin a subtraction (only honoured in IDLE)
//     a, b        : minuend / subtrahend, captured on the accepting edge
//     busy        : state is not IDLE
//     done        : one-cycle result-valid pulse
//     diff        : a - b modulo 2^WIDTH (holds until next completion)
//     borrow_out  : unsigned a < b
//     ovf         : two's-complement overflow of a - b
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SS_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;
  logic             w_d, w_bout, w_last;

  onebit_fs u_fs (
    .x    (r_a[0]),
    .y    (r_b[0]),
    .bin  (r_bin),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  // datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_bin      <= 1'b0;
      r_cnt      <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else if (r_state == IDLE) begin
      if (start) begin
        r_a   <= a;
        r_b   <= b;
        r_bin <= 1'b0;
        r_cnt <= '0;
      end
    end else if (r_state == SHIFT) begin
      r_acc <= {w_d, r_acc[WIDTH-1:1]};
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_bin <= w_bout;
      r_cnt <= r_cnt + CW'(1);
      if (w_last) begin
        diff       <= {w_d, r_acc[WIDTH-1:1]};
        borrow_out <= w_bout;
        // On the last step the LSBs of r_a/r_b are the captured operand
        // MSBs and w_d is the result MSB.
        ovf        <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow_out, ovf;
  logic [W-1:0] diff;

  logic fs_x = 1'b0, fs_y = 1'b0, fs_bin = 1'b0, fs_d, fs_bout;

  int n_vec = 0;
  int n_err = 0;

  // expected held result {borrow, ovf, diff}
  logic [W+1:0] held = '0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out), .ovf(ovf)
  );

  onebit_fs u_fs_tb (.x(fs_x), .y(fs_y), .bin(fs_bin), .d(fs_d), .bout(fs_bout));

  typedef struct {
    logic x, y, bin, d, bout;
  } fs_vec_t;

  typedef struct {
    logic [W-1:0] a, b, diff;
    logic         borrow, ovf, poke;
  } op_vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on the operands
  function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb_);
    int ua, ub, sa, sb, r;
    logic [W-1:0] d;
    ua = int'(ta);
    ub = int'(tb_);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    r  = sa - sb;
    d  = W'((ua - ub + 256) % 256);
    return {ua < ub, (r > 127) || (r < -128), d};
  endfunction

  // one full operation; poke disturbs start/a/b during SHIFT and DONE
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic poke, input logic [W+1:0] exp);
    int lat;
    @(negedge clk);
    start = 1'b1; a = ta; b = tb_;
    @(posedge clk);                      // accepting edge
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    lat = 0;
    for (int c = 1; c <= W + 4 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
      else begin
        chk("hold_result", {borrow_out, ovf, diff}, held);
        chk("busy_shift", busy, 1'b1);
      end
      if (poke && c == 3) begin
        @(negedge clk); start = 1'b1; a = W'($urandom); b = W'($urandom);
      end
      if (poke && c == 4) begin
        @(negedge clk); start = 1'b0;
      end
    end
    chk("latency", lat, W);
    chk("result", {borrow_out, ovf, diff}, exp);
    held = exp;
    if (poke) begin
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      chk("done_one_cycle", {done, busy}, 2'b00);
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      chk("start_in_done_ignored", busy, 1'b0);
    end else begin
      @(posedge clk); #1;
      chk("done_one_cycle", {done, busy}, 2'b00);
    end
  endtask

  fs_vec_t fs_tab[8];
  op_vec_t op_tab[5];

  initial begin
    int cyc, ndone, first;
    int dcyc[3];

    fs_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fs_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    fs_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    fs_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    fs_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    fs_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    fs_tab[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    fs_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    op_tab[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0};
    op_tab[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0, 1'b0};
    op_tab[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0};
    op_tab[3] = '{8'h5A, 8'h33, 8'h27, 1'b0, 1'b0, 1'b1};
    op_tab[4] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1, 1'b0};

    // reset state
    #3;
    chk("reset_outputs", {busy, done, borrow_out, ovf, diff}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // full-subtractor truth table
    foreach (fs_tab[i]) begin
      fs_x = fs_tab[i].x; fs_y = fs_tab[i].y; fs_bin = fs_tab[i].bin;
      #1;
      chk($sformatf("fs_%0d", i), {fs_d, fs_bout}, {fs_tab[i].d, fs_tab[i].bout});
    end

    // directed operations
    foreach (op_tab[i])
      run_op(op_tab[i].a, op_tab[i].b, op_tab[i].poke,
             {op_tab[i].borrow, op_tab[i].ovf, op_tab[i].diff});

    // reset in the 4th SHIFT cycle: outputs clear at once, no done
    @(negedge clk);
    start = 1'b1; a = 8'h55; b = 8'h11;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs", {busy, done, borrow_out, ovf, diff}, '0);
    @(negedge clk);
    rst = 1'b0;
    held = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", {done, busy}, 2'b00);
    end
    run_op(8'h01, 8'h02, 1'b0, {1'b1, 1'b0, 8'hFF});

    // start held high: back-to-back runs every W+2 cycles
    @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    cyc = 0; ndone = 0; first = 0;
    while (ndone < 3 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        dcyc[ndone] = cyc;
        ndone++;
        chk("ff_result", {borrow_out, ovf, diff}, '0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("b2b_count", ndone, 3);
    if (ndone == 3) begin
      chk("b2b_first", dcyc[0], W + 1);
      chk("b2b_space1", dcyc[1] - dcyc[0], W + 2);
      chk("b2b_space2", dcyc[2] - dcyc[1], W + 2);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_b2b", busy, 1'b0);
    held = '0;

    // randomized operations against the model
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ra;
      run_op(ra, rb, 1'(i % 3 == 0), model(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
